// File: rtl/adder_pkg.sv
// Shared definitions for the chunked adder: FSM state encoding and
// elaboration-time helpers for the chunk count and index width.
package adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Guarded against CHUNK < 1 so the config check, not a divide-by-zero, reports the error.
  function automatic int nchunk(input int width, input int chunk);
    return (chunk < 1) ? 1 : width / chunk;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/chunk_add.sv
// Combinational CHUNK-bit ripple of fulladd cells; cm is the carry into the
// MSB cell, needed for signed-overflow detection.
module chunk_add #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             cm
);

  // Per-stage carry nets keep each bit's carry a separate signal.
  for (genvar gi = 0; gi < CHUNK; gi++) begin : g_fa
    logic c_in;
    logic c_out;
    if (gi == 0) begin : g_first
      assign c_in = ci;
    end else begin : g_next
      assign c_in = g_fa[gi-1].c_out;
    end
    fulladd u_fa (
      .a (x[gi]),
      .b (y[gi]),
      .ci(c_in),
      .s (s[gi]),
      .co(c_out)
    );
  end

  assign co = g_fa[CHUNK-1].c_out;
  assign cm = g_fa[CHUNK-1].c_in;

endmodule

// File: rtl/fulladd.sv
// Single-bit full adder cell, the building block of the chunk ripple.
module fulladd (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle WIDTH-bit adder, CHUNK bits per clock, with start/busy/done handshake.
// Define SEQ_CHUNK_ADDER_OVF_EN to add the registered signed-overflow output ovf.
module seq_chunk_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SEQ_CHUNK_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int IDX_W  = idx_width(NCHUNK);

  if (CHUNK < 1) begin : g_bad_chunk
    $error("seq_chunk_adder: CHUNK must be at least 1");
  end else if (WIDTH % CHUNK != 0) begin : g_bad_width
    $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK");
  end

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0] sum_reg, sum_next;
  logic             carry_reg, carry_next;
  logic             cout_reg, cout_next;
  logic [IDX_W-1:0] idx_reg, idx_next;

  logic [31:0]      shamt;
  logic [WIDTH-1:0] a_shift, b_shift, acc_upd;
  logic [CHUNK-1:0] chunk_x, chunk_y, chunk_s;
  logic             chunk_co, chunk_cm;
  logic             last_chunk;

  // Shifts rather than variable part-selects to select the active chunk.
  assign shamt      = 32'(idx_reg) * 32'(CHUNK);
  assign a_shift    = a_reg >> shamt;
  assign b_shift    = b_reg >> shamt;
  assign chunk_x    = a_shift[CHUNK-1:0];
  assign chunk_y    = b_shift[CHUNK-1:0];
  assign acc_upd    = acc_reg | (WIDTH'(chunk_s) << shamt);
  assign last_chunk = (idx_reg == IDX_W'(NCHUNK - 1));

  chunk_add #(.CHUNK(CHUNK)) u_chunk (
    .x (chunk_x),
    .y (chunk_y),
    .ci(carry_reg),
    .s (chunk_s),
    .co(chunk_co),
    .cm(chunk_cm)
  );

`ifdef SEQ_CHUNK_ADDER_OVF_EN
  logic ovf_reg, ovf_next;
  assign ovf = ovf_reg;
`else
  logic unused_cm;
  assign unused_cm = chunk_cm;
`endif

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    acc_next   = acc_reg;
    sum_next   = sum_reg;
    carry_next = carry_reg;
    cout_next  = cout_reg;
    idx_next   = idx_reg;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    ovf_next   = ovf_reg;
`endif
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_next     = a;
          b_next     = b;
          carry_next = cin;
          acc_next   = '0;
          idx_next   = '0;
          state_next = ST_RUN;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        acc_next   = acc_upd;
        carry_next = chunk_co;
        idx_next   = idx_reg + 1'b1;
        if (last_chunk) begin
          sum_next   = acc_upd;
          cout_next  = chunk_co;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
          ovf_next   = chunk_cm ^ chunk_co;
`endif
          state_next = ST_DONE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
      idx_reg   <= '0;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
      ovf_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      acc_reg   <= acc_next;
      sum_reg   <= sum_next;
      carry_reg <= carry_next;
      cout_reg  <= cout_next;
      idx_reg   <= idx_next;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
      ovf_reg   <= ovf_next;
`endif
    end
  end

  assign busy = (state_reg == ST_RUN);
  assign done = (state_reg == ST_DONE);
  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Self-checking bench: directed and random 16/4 operations plus an exhaustive
// WIDTH=4 sweep over CHUNK 1, 2 and 4, checked against plain integer addition.
module tb_seq_chunk_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start16, cin16, busy16, done16, cout16;
  logic [15:0] a16, b16, sum16;

  logic        s_start, s_cin;
  logic [3:0]  s_a, s_b;
  logic [2:0]  s_busy, s_done, s_cout;
  logic [3:0]  s_sum [3];

`ifdef SEQ_CHUNK_ADDER_OVF_EN
  logic        ovf16;
  logic [2:0]  s_ovf;
`endif

  int compared   = 0;
  int mismatched = 0;

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .cin(cin16),
    .busy(busy16), .done(done16), .sum(sum16), .cout(cout16)
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    , .ovf(ovf16)
`endif
  );

  seq_chunk_adder #(.WIDTH(4), .CHUNK(1)) u_w4c1 (
    .clk(clk), .rst(rst), .start(s_start), .a(s_a), .b(s_b), .cin(s_cin),
    .busy(s_busy[0]), .done(s_done[0]), .sum(s_sum[0]), .cout(s_cout[0])
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    , .ovf(s_ovf[0])
`endif
  );

  seq_chunk_adder #(.WIDTH(4), .CHUNK(2)) u_w4c2 (
    .clk(clk), .rst(rst), .start(s_start), .a(s_a), .b(s_b), .cin(s_cin),
    .busy(s_busy[1]), .done(s_done[1]), .sum(s_sum[1]), .cout(s_cout[1])
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    , .ovf(s_ovf[1])
`endif
  );

  seq_chunk_adder #(.WIDTH(4), .CHUNK(4)) u_w4c4 (
    .clk(clk), .rst(rst), .start(s_start), .a(s_a), .b(s_b), .cin(s_cin),
    .busy(s_busy[2]), .done(s_done[2]), .sum(s_sum[2]), .cout(s_cout[2])
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    , .ovf(s_ovf[2])
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    compared++;
    assert (obs === expv)
    else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // One 16-bit operation; optional start pulse mid-RUN that must be ignored.
  task automatic run16(input logic [15:0] ta, input logic [15:0] tbv, input logic tci,
                       input bit poke, input string tag);
    logic [16:0] expv;
    logic [15:0] held;
    int n, nbusy, nhold;
    expv = {1'b0, ta} + {1'b0, tbv} + 17'(tci);
    held = sum16;
    a16 = ta; b16 = tbv; cin16 = tci; start16 = 1'b1;
    tick;
    start16 = 1'b0;
    a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
    n = 1; nbusy = 0; nhold = 0;
    while (!done16 && n < 20) begin
      if (busy16) nbusy++;
      if (sum16 !== held) nhold++;
      if (poke) start16 = (n == 2);
      tick;
      n++;
    end
    start16 = 1'b0;
    check({tag, "_latency"}, 64'(n), 64'd5);
    check({tag, "_busy_cycles"}, 64'(nbusy), 64'd4);
    check({tag, "_sum_held_in_run"}, 64'(nhold), 64'd0);
    check({tag, "_busy_at_done"}, 64'(busy16), 64'd0);
    check({tag, "_sum"}, 64'(sum16), 64'(expv[15:0]));
    check({tag, "_cout"}, 64'(cout16), 64'(expv[16]));
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    check({tag, "_ovf"}, 64'(ovf16),
          64'((ta[15] == tbv[15]) && (expv[15] != ta[15])));
`endif
  endtask

  initial begin
    int ndone;
    int lat [3];
    int exp_lat [3];
    logic [4:0] sexp;

    exp_lat = '{5, 3, 2};
    rst = 1'b1; start16 = 1'b0; a16 = '0; b16 = '0; cin16 = 1'b0;
    s_start = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0;
    tick; tick;
    rst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      check("rst_busy", 64'(busy16), 64'd0);
      check("rst_done", 64'(done16), 64'd0);
      check("rst_sum", 64'(sum16), 64'd0);
      check("rst_cout", 64'(cout16), 64'd0);
`ifdef SEQ_CHUNK_ADDER_OVF_EN
      check("rst_ovf", 64'(ovf16), 64'd0);
`endif
      tick;
    end

    run16(16'hFFFF, 16'h0001, 1'b0, 1'b0, "carry_wrap");
    tick;
    check("done_one_cycle", 64'(done16), 64'd0);

    run16(16'h7FFF, 16'h0001, 1'b0, 1'b0, "signed_ovf");
    tick;

    // Back-to-back start in the DONE cycle, with a mid-RUN start pulse
    run16(16'h0F0F, 16'h00F1, 1'b0, 1'b0, "b2b_first");
    run16(16'h1234, 16'h1111, 1'b1, 1'b1, "b2b_second");
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (done16) ndone++;
    end
    check("b2b_extra_done", 64'(ndone), 64'd0);

    // Reset in the second RUN cycle aborts the operation
    a16 = 16'hAAAA; b16 = 16'h5555; cin16 = 1'b0; start16 = 1'b1;
    tick;
    start16 = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("abort_busy", 64'(busy16), 64'd0);
    check("abort_done", 64'(done16), 64'd0);
    check("abort_sum", 64'(sum16), 64'd0);
    check("abort_cout", 64'(cout16), 64'd0);
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      if (done16 || busy16) ndone++;
      tick;
    end
    check("abort_no_done", 64'(ndone), 64'd0);

    // Random operations, some chained, some with idle gaps and mid-RUN pokes
    for (int i = 0; i < 24; i++) begin
      run16(16'($urandom), 16'($urandom), 1'($urandom), bit'($urandom_range(0, 1)),
            $sformatf("rand%0d", i));
      if ($urandom_range(0, 1) == 1) tick;
    end
    tick;

    // Exhaustive WIDTH=4 sweep for CHUNK 1, 2, 4
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          s_a = 4'(ia); s_b = 4'(ib); s_cin = 1'(ic); s_start = 1'b1;
          tick;
          s_start = 1'b0;
          s_a = 4'($urandom); s_b = 4'($urandom); s_cin = 1'($urandom);
          lat = '{0, 0, 0};
          for (int n = 2; n <= 7; n++) begin
            tick;
            for (int j = 0; j < 3; j++)
              if (s_done[j] && lat[j] == 0) lat[j] = n;
          end
          sexp = 5'(ia + ib + ic);
          for (int j = 0; j < 3; j++) begin
            check($sformatf("sweep_c%0d_a%0d_b%0d_ci%0d_sum", exp_lat[j], ia, ib, ic),
                  64'({s_cout[j], s_sum[j]}), 64'(sexp));
            check($sformatf("sweep_c%0d_a%0d_b%0d_ci%0d_lat", exp_lat[j], ia, ib, ic),
                  64'(lat[j]), 64'(exp_lat[j]));
          end
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
